multicycle_ctrl: RTL

Multicycle control unit for the ARM-subset processor. A Moore FSM sequences the shared datapath (PC, instruction register, ALU, register file, memory) through fetch, decode, execute and writeback. It decodes the ALU operation and flag-write controls, and holds the NZCV flag register. It evaluates the instruction's condition field against the stored flags and gates every architectural write with the result.

---
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl_if : instruction fields / datapath controls bundle          |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface multicycle_ctrl_if;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic       IRWrite;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic [1:0] ALUControl;
   logic [3:0] state;

   // Datapath side: supplies instruction fields and ALU flags.
   modport master (
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
      input  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, state
   );

   // Controller side.
   modport slave (
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
      output ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, state
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl : Moore FSM, ALU decode, NZCV flags and condition gating    |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module multicycle_ctrl (
   input  wire logic          clk,
   input  wire logic          reset_n,
   multicycle_ctrl_if.slave   bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_flags;   // {N,Z,C,V}
   logic       r_cond;

   logic       w_next_pc, w_regw, w_memw, w_branch, w_aluop, w_irwrite;
   logic       w_adrsrc, w_alusrca;
   logic [1:0] w_alusrcb, w_resultsrc;
   logic [1:0] w_alu_ctrl, w_flagw;
   logic       w_nowrite, w_cond_ex, w_pcs;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_FETCH;
         r_flags <= 4'b0000;
         r_cond  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE)
            r_cond <= w_cond_ex;
         if ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI)) begin
            if (w_flagw[1] && r_cond) r_flags[3:2] <= bus.ALUFlags[3:2];
            if (w_flagw[0] && r_cond) r_flags[1:0] <= bus.ALUFlags[1:0];
         end
      end
   end

   always_comb begin
      w_next      = S_FETCH;
      w_next_pc   = 1'b0;
      w_regw      = 1'b0;
      w_memw      = 1'b0;
      w_branch    = 1'b0;
      w_aluop     = 1'b0;
      w_irwrite   = 1'b0;
      w_adrsrc    = 1'b0;
      w_alusrca   = 1'b0;
      w_alusrcb   = 2'b00;
      w_resultsrc = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_next      = S_DECODE;
            w_alusrca   = 1'b1;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
            w_irwrite   = 1'b1;
            w_next_pc   = 1'b1;
         end
         S_DECODE: begin
            w_alusrca   = 1'b1;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
            case (bus.Op)
               2'b01:   w_next = S_MEMADR;
               2'b00:   w_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b10:   w_next = S_BRANCH;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            w_alusrcb = 2'b01;
            w_next    = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_adrsrc = 1'b1;
            w_next   = S_MEMWB;
         end
         S_MEMWB: begin
            w_resultsrc = 2'b01;
            w_regw      = 1'b1;
         end
         S_MEMWRITE: begin
            w_adrsrc = 1'b1;
            w_memw   = 1'b1;
         end
         S_EXECUTER: begin
            w_aluop = 1'b1;
            w_next  = S_ALUWB;
         end
         S_EXECUTEI: begin
            w_alusrcb = 2'b01;
            w_aluop   = 1'b1;
            w_next    = S_ALUWB;
         end
         S_ALUWB: begin
            w_regw = 1'b1;
         end
         S_BRANCH: begin
            w_alusrcb   = 2'b01;
            w_resultsrc = 2'b10;
            w_branch    = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // NoWrite is decoded from the fields alone so it still masks the ALUWB write of a CMP.
   always_comb begin
      w_alu_ctrl = 2'b00;
      w_flagw    = 2'b00;
      w_nowrite  = (bus.Op == 2'b00) && (bus.Funct[4:1] == 4'b1010);
      if (w_aluop) begin
         case (bus.Funct[4:1])
            4'b0100: w_alu_ctrl = 2'b00;
            4'b0010: w_alu_ctrl = 2'b01;
            4'b0000: w_alu_ctrl = 2'b10;
            4'b1100: w_alu_ctrl = 2'b11;
            4'b1010: w_alu_ctrl = 2'b01;
            default: w_alu_ctrl = 2'b00;
         endcase
         w_flagw[1] = bus.Funct[0];
         w_flagw[0] = bus.Funct[0] && (w_alu_ctrl[1] == 1'b0);
         if (bus.Funct[4:1] == 4'b1010)
            w_flagw = 2'b11;
      end
   end

   always_comb begin
      w_cond_ex = 1'b0;
      case (bus.Cond)
         4'b0000: w_cond_ex = r_flags[2];
         4'b0001: w_cond_ex = ~r_flags[2];
         4'b0010: w_cond_ex = r_flags[1];
         4'b0011: w_cond_ex = ~r_flags[1];
         4'b0100: w_cond_ex = r_flags[3];
         4'b0101: w_cond_ex = ~r_flags[3];
         4'b0110: w_cond_ex = r_flags[0];
         4'b0111: w_cond_ex = ~r_flags[0];
         4'b1000: w_cond_ex = r_flags[1] & ~r_flags[2];
         4'b1001: w_cond_ex = ~r_flags[1] | r_flags[2];
         4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
         4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
         4'b1100: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
         4'b1101: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
         4'b1110: w_cond_ex = 1'b1;
         default: w_cond_ex = 1'b0;
      endcase
   end

   assign w_pcs = w_branch | (w_regw & (bus.Rd == 4'd15));

   // Write enables are held low combinationally for the whole reset assertion.
   assign bus.RegWrite   = w_regw & r_cond & ~w_nowrite & reset_n;
   assign bus.MemWrite   = w_memw & r_cond & reset_n;
   assign bus.PCWrite    = (w_next_pc | (w_pcs & r_cond)) & reset_n;
   assign bus.IRWrite    = w_irwrite & reset_n;
   assign bus.AdrSrc     = w_adrsrc;
   assign bus.ALUSrcA    = w_alusrca;
   assign bus.ALUSrcB    = w_alusrcb;
   assign bus.ResultSrc  = w_resultsrc;
   assign bus.ALUControl = w_alu_ctrl;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
   assign bus.state      = r_state;

endmodule
`default_nettype wire
